// File: rtl/jk_pkg.sv
// Shared definitions for the master-slave JK flip-flop: command encoding
// (indexed by {j,k}) and the default reset value.
package jk_pkg;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    localparam logic RESET_Q_DEFAULT = 1'b0;

endpackage

// File: rtl/jk_next_state.sv
// Combinational JK next-state function: d is the value the master stage
// captures, given the command {j,k} and the current slave output q.
module jk_next_state
    import jk_pkg::*;
(
    input  logic j,
    input  logic k,
    input  logic q,
    output logic d
);

    always_comb begin
        d = q;
        case ({j, k})
            JK_HOLD: d = q;
            JK_RST:  d = 1'b0;
            JK_SET:  d = 1'b1;
            JK_TGL:  d = ~q;
            default: d = q;
        endcase
    end

endmodule

// File: rtl/jk_ms_flipflop.sv
// Master-slave JK flip-flop: master captures on the rising edge, slave copies
// the master on the falling edge. Synchronous reset acts on the rising edge.
module jk_ms_flipflop
    import jk_pkg::*;
#(
    parameter logic RESET_Q = RESET_Q_DEFAULT
) (
    output logic q,
    output logic q_bar,
    input  logic clk,
    input  logic j,
    input  logic k,
    input  logic rst
);

    logic m_reg;
    logic s_reg;
    logic rst_pend_reg;
    logic m_next;

    jk_next_state u_next_state (
        .j (j),
        .k (k),
        .q (q),
        .d (m_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            m_reg        <= RESET_Q;
            rst_pend_reg <= 1'b1;
        end else begin
            m_reg        <= m_next;
            rst_pend_reg <= 1'b0;
        end
    end

    always_ff @(negedge clk) begin
        s_reg <= m_reg;
    end

    // A reset edge forces q immediately rather than waiting half a cycle for
    // the slave; by the following falling edge s_reg holds RESET_Q anyway.
    assign q     = rst_pend_reg ? RESET_Q : s_reg;
    assign q_bar = ~q;

endmodule

// File: tb/tb_jk_ms_flipflop.sv
// Directed testbench for jk_ms_flipflop; clock period 20, rising edges at 10, 30, ...
module tb_jk_ms_flipflop;

    logic clk;
    logic rst;
    logic j;
    logic k;
    logic q;
    logic q_bar;

    int pass_cnt  = 0;
    int total_cnt = 0;

    jk_ms_flipflop dut (
        .q     (q),
        .q_bar (q_bar),
        .clk   (clk),
        .j     (j),
        .k     (k),
        .rst   (rst)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    initial begin
        #90000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // Reset from power-up; q must be 0 right at the first rising edge and
    // stay 0 through the following falling edges with j=k=0.
    task automatic test_reset();
        rst = 1'b1;
        j   = 1'b0;
        k   = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({q, q_bar} !== 2'b01)
            $display("FAIL reset_edge: q=%b q_bar=%b required q=0 q_bar=1", q, q_bar);
        else pass_cnt++;
        $display("t=%0t reset_edge q=%b q_bar=%b", $time, q, q_bar);
        #4 rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if ({q, q_bar} !== 2'b01)
                $display("FAIL reset_hold_%0d: q=%b q_bar=%b required q=0 q_bar=1", i, q, q_bar);
            else pass_cnt++;
            $display("t=%0t reset_hold_%0d q=%b q_bar=%b", $time, i, q, q_bar);
        end
    endtask

    // Re-reset between tests: entered 1 after a falling edge, leaves 1 after a falling edge.
    task automatic do_reset();
        rst = 1'b1;
        j   = 1'b0;
        k   = 1'b0;
        @(posedge clk);
        #5 rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    // Set: master captures at a rising edge, q follows only at the falling edge.
    task automatic test_set();
        j = 1'b1;
        k = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({q, q_bar} !== 2'b01)
            $display("FAIL set_not_at_rise: q=%b q_bar=%b required q=0 q_bar=1", q, q_bar);
        else pass_cnt++;
        $display("t=%0t set_not_at_rise q=%b", $time, q);
        #8;
        total_cnt++;
        if (q !== 1'b0)
            $display("FAIL set_before_fall: q=%b required 0", q);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({q, q_bar} !== 2'b10)
            $display("FAIL set_at_fall: q=%b q_bar=%b required q=1 q_bar=0", q, q_bar);
        else pass_cnt++;
        $display("t=%0t set_at_fall q=%b", $time, q);
    endtask

    // Reset command from q=1, then hold.
    task automatic test_rst_cmd();
        j = 1'b0;
        k = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (q !== 1'b1)
            $display("FAIL rstcmd_at_rise: q=%b required 1", q);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({q, q_bar} !== 2'b01)
            $display("FAIL rstcmd_at_fall: q=%b q_bar=%b required q=0 q_bar=1", q, q_bar);
        else pass_cnt++;
        $display("t=%0t rstcmd_at_fall q=%b", $time, q);
        k = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if (q !== 1'b0)
                $display("FAIL rstcmd_hold_%0d: q=%b required 0", i, q);
            else pass_cnt++;
        end
    endtask

    // Toggle: q inverts once per period, from 0.
    task automatic test_toggle();
        logic exp_q;
        exp_q = 1'b0;
        j = 1'b1;
        k = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_q = ~exp_q;
            @(posedge clk);
            #1;
            total_cnt++;
            if ({q, q_bar} !== {~exp_q, exp_q})
                $display("FAIL toggle_rise_%0d: q=%b q_bar=%b required q=%b", i, q, q_bar, ~exp_q);
            else pass_cnt++;
            @(negedge clk);
            #1;
            total_cnt++;
            if ({q, q_bar} !== {exp_q, ~exp_q})
                $display("FAIL toggle_fall_%0d: q=%b q_bar=%b required q=%b", i, q, q_bar, exp_q);
            else pass_cnt++;
            $display("t=%0t toggle_%0d q=%b q_bar=%b", $time, i, q, q_bar);
        end
        j = 1'b0;
        k = 1'b0;
    endtask

    // Glitches on j/k between rising edges and changes at a falling edge.
    task automatic test_glitch();
        j = 1'b1;
        k = 1'b0;
        @(posedge clk);
        #5 j = 1'b0;
        #4 j = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (q !== 1'b1)
            $display("FAIL glitch_set: q=%b required 1", q);
        else pass_cnt++;
        $display("t=%0t glitch_set q=%b", $time, q);
        #1 j = 1'b0;
        #6 j = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (q !== 1'b1)
            $display("FAIL glitch_jpulse: q=%b required 1", q);
        else pass_cnt++;
        j = 1'b0;
        // k pulse strictly between rising edges while holding
        #4 k = 1'b1;
        #3 k = 1'b0;
        @(negedge clk);
        #1;
        total_cnt++;
        if (q !== 1'b1)
            $display("FAIL glitch_kpulse: q=%b required 1", q);
        else pass_cnt++;
        // k raised at a falling edge must not affect that transfer
        @(negedge clk);
        k = 1'b1;
        #1;
        total_cnt++;
        if (q !== 1'b1)
            $display("FAIL fall_coincident: q=%b required 1", q);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if (q !== 1'b0)
            $display("FAIL fall_coincident_next: q=%b required 0", q);
        else pass_cnt++;
        $display("t=%0t fall_coincident_next q=%b", $time, q);
        k = 1'b0;
    endtask

    // Reset in the middle of a toggle sequence, then toggling resumes from 0.
    task automatic test_mid_reset();
        j = 1'b1;
        k = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (q !== 1'b1)
            $display("FAIL mid_pre_toggle: q=%b required 1", q);
        else pass_cnt++;
        rst = 1'b1;
        #5;
        total_cnt++;
        if (q !== 1'b1)
            $display("FAIL mid_rst_between_edges: q=%b required 1", q);
        else pass_cnt++;
        @(posedge clk);
        #1;
        total_cnt++;
        if ({q, q_bar} !== 2'b01)
            $display("FAIL mid_rst_at_rise: q=%b q_bar=%b required q=0 q_bar=1", q, q_bar);
        else pass_cnt++;
        $display("t=%0t mid_rst_at_rise q=%b", $time, q);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            total_cnt++;
            if ({q, q_bar} !== 2'b01)
                $display("FAIL mid_rst_hold_%0d: q=%b q_bar=%b required q=0 q_bar=1", i, q, q_bar);
            else pass_cnt++;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (q !== 1'b0)
            $display("FAIL mid_release_rise: q=%b required 0", q);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({q, q_bar} !== 2'b10)
            $display("FAIL mid_resume_1: q=%b q_bar=%b required q=1 q_bar=0", q, q_bar);
        else pass_cnt++;
        @(negedge clk);
        #1;
        total_cnt++;
        if ({q, q_bar} !== 2'b01)
            $display("FAIL mid_resume_0: q=%b q_bar=%b required q=0 q_bar=1", q, q_bar);
        else pass_cnt++;
        $display("t=%0t mid_resume q=%b", $time, q);
        j = 1'b0;
        k = 1'b0;
    endtask

    initial begin
        test_reset();
        test_set();
        test_rst_cmd();
        do_reset();
        test_toggle();
        do_reset();
        test_glitch();
        do_reset();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/jk_ms_flipflop.md
JK_MS_FLIPFLOP -- requirements
Module: jk_ms_flipflop

Interface
REQ-001 Parameter: RESET_Q, default 1'b0, value loaded into master and slave by reset.
REQ-002 Port clk, input, 1 bit: single clock; master stage acts on rising edge, slave stage on falling edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous, active-high, sampled on rising edge of clk.
REQ-004 Port j, input, 1 bit: JK set input.
REQ-005 Port k, input, 1 bit: JK reset input.
REQ-006 Port q, output, 1 bit: slave (true) output.
REQ-007 Port q_bar, output, 1 bit: complement output.
REQ-008 Positional port order SHALL be q, q_bar, clk, j, k, rst, so existing positional instantiations (q, q_bar, clk, j, k) keep their mapping.

Function
REQ-009 Master register m SHALL update only on rising clk edge: next = f(j, k, q) using the slave output q as current state.
REQ-010 JK function: j=0,k=0 -> hold (m<=q); j=0,k=1 -> m<=0; j=1,k=0 -> m<=1; j=1,k=1 -> m<=~q.
REQ-011 Slave register (drives q) SHALL update only on falling clk edge: q<=m.
REQ-012 q SHALL change only at falling edges (half-cycle latency after master capture); j/k changes between rising edges SHALL have no effect on q.
REQ-013 Toggle with j=k=1 held SHALL invert q exactly once per full clk period, never oscillating within a period.
REQ-014 q_bar SHALL equal ~q combinationally at all times, including during and after reset.
REQ-015 j/k changes coincident with a falling edge SHALL NOT affect that falling-edge transfer; only the value sampled at the preceding rising edge counts.
REQ-016 No X SHALL appear on q/q_bar after the first reset; before the first reset, outputs are undefined.

Reset
REQ-017 rst=1 at a rising edge SHALL load m and q with RESET_Q at that edge (q updates at the rising edge, overriding REQ-012), ignoring j/k.
REQ-018 While rst stays high, falling edges SHALL keep q=RESET_Q (m already holds RESET_Q).
REQ-019 rst asserted or deasserted between rising edges SHALL have no effect until the next rising edge; reset mid-toggle sequence aborts the toggle.
REQ-020 After rst deasserts, the first rising edge SHALL evaluate REQ-010 from q=RESET_Q.

Structure
REQ-021 Shared package jk_pkg SHALL hold the JK command encoding constants JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11 (index {j,k}) and the default RESET_Q.
REQ-022 One combinational sub-module jk_next_state (inputs j, k, q; output d) SHALL implement REQ-010; the top SHALL contain the two registers and the inverter.
REQ-023 Implementation SHALL be synthesizable: no latches, no delays, no initial blocks.

Verification (clk period 20, rising edges at 10, 30, 50 ...)
REQ-024 Reset: rst=1 over rising edge t=10 -> q=0, q_bar=1 from t=10; hold j=k=0 to t=60 -> q stays 0 through falling edges 20, 40, 60.
REQ-025 Reset + set: rst=1 until t=10, then j=1, k=0 at t=15 -> m=1 at t=30, q rises at t=40, not at t=30.
REQ-026 Reset: j=0, k=1 from q=1 -> q falls at the first falling edge after the next rising edge; j=k=0 afterwards -> q held.
REQ-027 Toggle: j=k=1 held 4 periods from q=0 -> q sequence 1,0,1,0 at consecutive falling edges; q_bar always complementary.
REQ-028 Glitch immunity: j=1 at rising edge 30, j pulsed 0 during 35-39, k=0 -> q=1 at t=40; j=0 pulse entirely between 42-48 -> no change.
REQ-029 Mid-operation reset: toggling with j=k=1, rst=1 at rising edge 90 -> q=0 at t=90 and stays 0 while rst=1; release -> toggling resumes from 0.
